// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// ifetch_pkg : shared fetch-stage constants and FSM state type
// Revision   : 1.0
// ============================================================================
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } ifetch_state_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
// ifetch_if : instruction-memory request/response channel
// Revision  : 1.0
// ============================================================================
interface ifetch_if #(
    parameter int XLEN = 64
) ();

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/ifetch_skid.sv
`default_nettype none
// ============================================================================
// fetch_skid : one-entry {pc, instr} buffer with load / unload / clear
// Revision   : 1.0
// ============================================================================
module fetch_skid
    import ifetch_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_load,
    input  wire logic            i_unload,
    input  wire logic            i_clear,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [31:0]     i_instr,
    output logic                 o_valid,
    output logic      [XLEN-1:0] o_pc,
    output logic      [31:0]     o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;

    // Clear wins so a flush can never leave a wrong-path word behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// ifetch : fetch PC, single-outstanding imem requests, IF/ID register + skid
// Revision : 1.0
// ============================================================================
module ifetch
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            stall,
    input  wire logic            flush,
    input  wire logic [XLEN-1:0] redirect_pc,
    ifetch_if.master             imem,
    output logic      [XLEN-1:0] pc,
    output logic      [31:0]     instr,
    output logic                 instr_valid
);

    ifetch_state_t   r_state;
    ifetch_state_t   w_state_n;
    logic            r_run;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_fetch_pc_n;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_n;
    logic [31:0]     r_instr;
    logic [31:0]     w_instr_n;
    logic            r_valid;
    logic            w_valid_n;
    logic            w_req_valid;
    logic            w_skid_load;
    logic            w_skid_unload;
    logic            w_skid_clear;
    logic            w_skid_valid;
    logic [XLEN-1:0] w_skid_pc;
    logic [31:0]     w_skid_instr;
    logic [XLEN-1:0] w_rsp_pc;

    // fetch_pc only advances on acceptance, so the outstanding request is 4 behind.
    assign w_rsp_pc = r_fetch_pc - XLEN'(4);

    fetch_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_pc     (w_rsp_pc),
        .i_instr  (imem.imem_rsp_data),
        .o_valid  (w_skid_valid),
        .o_pc     (w_skid_pc),
        .o_instr  (w_skid_instr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_pc       <= '0;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_run      <= 1'b1;
            r_fetch_pc <= w_fetch_pc_n;
            r_pc       <= w_pc_n;
            r_instr    <= w_instr_n;
            r_valid    <= w_valid_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_fetch_pc_n  = r_fetch_pc;
        w_pc_n        = r_pc;
        w_instr_n     = r_instr;
        w_valid_n     = r_valid;
        w_req_valid   = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_clear  = 1'b0;

        // Decode takes the current word whenever it is not stalled.
        if (!stall) begin
            w_valid_n = 1'b0;
            w_instr_n = NOP_INSTR;
        end

        case (r_state)
            FETCH: begin
                w_req_valid = r_run;
                if (r_run && imem.imem_req_ready) begin
                    w_state_n    = WAIT;
                    w_fetch_pc_n = r_fetch_pc + XLEN'(4);
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (!stall) begin
                        w_pc_n      = w_rsp_pc;
                        w_instr_n   = imem.imem_rsp_data;
                        w_valid_n   = 1'b1;
                        w_req_valid = !flush;
                        if (!flush && imem.imem_req_ready) begin
                            w_fetch_pc_n = r_fetch_pc + XLEN'(4);
                        end else begin
                            w_state_n = FETCH;
                        end
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_n   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    w_pc_n        = w_skid_pc;
                    w_instr_n     = w_skid_instr;
                    w_valid_n     = w_skid_valid;
                    w_skid_unload = 1'b1;
                    w_state_n     = FETCH;
                end
            end
            DRAIN: begin
                if (imem.imem_rsp_valid) begin
                    w_state_n = FETCH;
                end
            end
            default: begin
                w_state_n = FETCH;
            end
        endcase

        // A request still in flight after this edge must be drained before refetching.
        if (flush) begin
            w_fetch_pc_n  = redirect_pc & ~(XLEN'(3));
            w_pc_n        = '0;
            w_instr_n     = NOP_INSTR;
            w_valid_n     = 1'b0;
            w_skid_clear  = 1'b1;
            w_skid_load   = 1'b0;
            w_skid_unload = 1'b0;
            if (((r_state == WAIT) || (r_state == DRAIN)) && !imem.imem_rsp_valid) begin
                w_state_n = DRAIN;
            end else if ((r_state == FETCH) && r_run && imem.imem_req_ready) begin
                w_state_n = DRAIN;
            end else begin
                w_state_n = FETCH;
            end
        end
    end

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_fetch_pc;
    assign pc                  = r_pc;
    assign instr               = r_instr;
    assign instr_valid         = r_valid;

endmodule
`default_nettype wire
